fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-side controller for the dual-clock FIFO test path. It is the upstream counterpart of the FIFO read controller. It waits until the FIFO reports empty, lets the status flags settle, then writes an incrementing byte pattern every cycle until the FIFO reports full, and then hands the FIFO over to the reader. The reader drains from full to empty, so the two controllers ping-pong the FIFO between completely full and completely empty.

## Interface
Parameters:
- DATA_W, 8: width of `wr_data`.
- START_VAL, 0: first data value after reset.
- SETTLE_CYC, 3: wait cycles after `wr_empty` is seen before writing starts; covers flag latency in the FIFO. Range 0..15.
- LEN_W, 9: width of `burst_len`. Must hold FIFO depth.

Ports:
- clk  in  1  write-domain clock; one clock only.
- rst  in  1  synchronous, active-high reset.
- en  in  1  allows a new burst to start; sampled only in IDLE.
- wr_full  in  1  FIFO full flag, write side.
- wr_empty  in  1  FIFO empty flag, write side.
- wr_req  out  1  FIFO write request.
- wr_data  out  DATA_W  data presented with `wr_req`.
- busy  out  1  high in SETTLE or WRITE.
- burst_done  out  1  one-cycle pulse when a burst ends.
- burst_len  out  LEN_W  number of words accepted in the last completed burst.

## Operation
- States: IDLE, SETTLE, WRITE.
- IDLE:
  - If `en` and `wr_empty` and not `wr_full`, go to SETTLE and clear the settle counter.
  - If SETTLE_CYC=0, go directly to WRITE.
- SETTLE:
  - The settle counter increments each cycle.
  - When it reaches SETTLE_CYC-1, go to WRITE and clear the word counter.
- WRITE:
  - `wr_req = (state==WRITE) & ~wr_full`. This is combinational; no write is ever issued while `wr_full` is high.
  - On every cycle with `wr_req` high, `wr_data` increments by 1 modulo 2^DATA_W, and the word counter increments.
  - When `wr_full` is sampled high, go to IDLE. That same edge loads `burst_len` from the word counter and pulses `burst_done`.
- Data does not restart per burst. It continues from the last value and wraps from 2^DATA_W-1 to 0.
- `en` dropping during SETTLE or WRITE does not abort the burst. Only `rst` aborts.
- If `wr_full` and `wr_empty` are both high (illegal): full wins. There is no transition out of IDLE, and no write occurs in WRITE.
- If `wr_full` is already high on WRITE entry: zero words are written, the controller returns to IDLE next cycle, and `burst_len`=0 with a `burst_done` pulse.
- The word counter saturates at 2^LEN_W-1; it never wraps.

## Timing
- Values after reset:
  - state = IDLE
  - `wr_req` = 0
  - `wr_data` = START_VAL
  - `busy` = 0
  - `burst_done` = 0
  - `burst_len` = 0
- Reset mid-burst: at the first edge with `rst` high, all registers take their reset values and `wr_req` falls in the same cycle. No partial-burst `burst_done` pulse is produced.
- Latency from the edge where `en` & `wr_empty` are sampled high to the first `wr_req`: SETTLE_CYC+1 cycles. With SETTLE_CYC=0, the latency is 1 cycle.
- `wr_data` is registered and stable for the whole cycle in which `wr_req` is high. The FIFO captures it on the next `clk` edge.
- Throughput: one word per cycle while in WRITE and not full.
- `burst_done` is high for exactly one cycle, namely the first cycle in IDLE after WRITE. `burst_len` is valid from that cycle until the next burst completes.

## Structure
- Shared package `fifo_ctrl_pkg` holds:
  - the state encoding constants (IDLE=2'd0, SETTLE=2'd1, WRITE=2'd2);
  - default FIFO depth (256) and DATA_W (8), shared with the read controller and the top level.
- One sub-module, `delay_cnt`:
  - a generic down-counter with load/expire;
  - used for the SETTLE wait;
  - reusable by the read side.
- Everything else is flat: FSM, data counter, word counter, and output register.

## Test plan
- Reset then `en`=1, `wr_empty`=1, SETTLE_CYC=3 -> first `wr_req` 4 cycles later with `wr_data`=0x00, followed by 0x01, 0x02, … on consecutive cycles.
- FIFO model of depth 256; `wr_full` asserts after 256 writes -> exactly 256 requests, last `wr_data`=0xFF, `burst_done` pulse, `burst_len`=256, `busy`=0.
- Second burst after the reader drains -> data starts at 0x00 (wrapped), `burst_len`=256 again.
- `wr_full` toggled low/high mid-burst (backpressure) -> `wr_req` low on every full cycle, no data value skipped or duplicated; the burst ends on the first full.
- `rst` asserted after the 100th write -> `wr_req` low from that cycle, `wr_data`=START_VAL, no `burst_done`; a restart produces a clean burst.
- `wr_full`=`wr_empty`=1 in IDLE with `en`=1 -> stays in IDLE, `wr_req` never asserts.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the dual-clock FIFO test-path controllers.
// The read controller, the write controller and the top level all use this package.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WRITE  = 2'd2
    } ctrl_state_t;

    localparam int FIFO_DEPTH   = 256;
    localparam int FIFO_DATA_W  = 8;
    localparam int SETTLE_CNT_W = 4;

    // The settle counter is a down-counter that expires at zero, so an
    // N-cycle wait preloads N-1.
    function automatic logic [SETTLE_CNT_W-1:0] settle_preload(input int cyc);
        if (cyc <= 0) begin
            return '0;
        end
        return SETTLE_CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/delay_cnt.sv
// Generic down-counter. Loading sets the count; it then decrements to zero
// and holds there, with expired high at zero.
module delay_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side FIFO test controller: waits for empty, settles, then fills the
// FIFO with an incrementing pattern until full and hands it to the reader.
module fifo_wr_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int                DATA_W     = FIFO_DATA_W,
    parameter logic [DATA_W-1:0] START_VAL  = '0,
    parameter int                SETTLE_CYC = 3,
    parameter int                LEN_W      = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_full,
    input  logic              wr_empty,
    output logic              wr_req,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              burst_done,
    output logic [LEN_W-1:0]  burst_len
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = settle_preload(SETTLE_CYC);

    ctrl_state_t      state;
    ctrl_state_t      state_nxt;
    logic             start_ok;
    logic             settle_load;
    logic             settle_done;
    logic             word_clr;
    logic             end_burst;
    logic [LEN_W-1:0] word_cnt;

    // Full overrides empty, so an illegal full+empty never starts a burst.
    assign start_ok = en & wr_empty & ~wr_full;

    delay_cnt #(
        .W (SETTLE_CNT_W)
    ) u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (settle_load),
        .load_val (SETTLE_LOAD),
        .expired  (settle_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        settle_load = 1'b0;
        word_clr    = 1'b0;
        end_burst   = 1'b0;
        wr_req      = 1'b0;
        busy        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_ok) begin
                    if (SETTLE_CYC == 0) begin
                        state_nxt = WRITE;
                        word_clr  = 1'b1;
                    end else begin
                        state_nxt   = SETTLE;
                        settle_load = 1'b1;
                    end
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_done) begin
                    state_nxt = WRITE;
                    word_clr  = 1'b1;
                end
            end
            WRITE: begin
                busy   = 1'b1;
                wr_req = ~wr_full;
                if (wr_full) begin
                    state_nxt = IDLE;
                    end_burst = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Data runs on across bursts; the word count restarts on each WRITE
    // entry and saturates rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_data    <= START_VAL;
            word_cnt   <= '0;
            burst_len  <= '0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= end_burst;
            if (end_burst) begin
                burst_len <= word_cnt;
            end
            if (wr_req) begin
                wr_data <= wr_data + DATA_W'(1);
            end
            if (word_clr) begin
                word_cnt <= '0;
            end else if (wr_req && (word_cnt != '1)) begin
                word_cnt <= word_cnt + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: a per-cycle vector table for the FSM
// edges, then full-burst sequences against a depth-256 FIFO model.
module tb_fifo_wr_ctrl;

    localparam int SETTLE_CYC = 3;
    localparam int DEPTH      = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       wr_full;
    logic       wr_empty;
    logic       wr_req;
    logic [7:0] wr_data;
    logic       busy;
    logic       burst_done;
    logic [8:0] burst_len;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_data;

    typedef struct {
        logic       rst;
        logic       en;
        logic       full;
        logic       empty;
        logic       exp_req;
        logic       exp_busy;
        logic       exp_done;
        logic [7:0] exp_data;
        logic [8:0] exp_len;
    } vec_t;

    vec_t vecs[21];

    fifo_wr_ctrl #(
        .DATA_W     (8),
        .START_VAL  (8'h00),
        .SETTLE_CYC (SETTLE_CYC),
        .LEN_W      (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .wr_full    (wr_full),
        .wr_empty   (wr_empty),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .busy       (busy),
        .burst_done (burst_done),
        .burst_len  (burst_len)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic f, input logic m,
                                input logic q, input logic b, input logic d,
                                input logic [7:0] dat, input logic [8:0] len);
        vec_t v;
        v.rst = r; v.en = e; v.full = f; v.empty = m;
        v.exp_req = q; v.exp_busy = b; v.exp_done = d;
        v.exp_data = dat; v.exp_len = len;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        rst      = v.rst;
        en       = v.en;
        wr_full  = v.full;
        wr_empty = v.empty;
        #1;
        check_output($sformatf("vec%0d wr_req", idx),     32'(wr_req),     32'(v.exp_req));
        check_output($sformatf("vec%0d busy", idx),       32'(busy),       32'(v.exp_busy));
        check_output($sformatf("vec%0d burst_done", idx), 32'(burst_done), 32'(v.exp_done));
        check_output($sformatf("vec%0d wr_data", idx),    32'(wr_data),    32'(v.exp_data));
        check_output($sformatf("vec%0d burst_len", idx),  32'(burst_len),  32'(v.exp_len));
        @(posedge clk);
        #1;
    endtask

    // Starts a burst from an empty FIFO; the model reports full once
    // max_words writes have been captured.
    task automatic run_burst(input int max_words, input logic [7:0] exp_last, input int exp_len);
        int         words;
        int         cyc;
        int         lat;
        int         viol;
        bit         done_seen;
        logic [7:0] last;
        words = 0; cyc = 0; lat = -1; viol = 0; done_seen = 1'b0; last = 8'h00;
        en = 1'b1; wr_full = 1'b0; wr_empty = 1'b1;
        @(posedge clk);
        #1;
        en  = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 2000) begin
            wr_full  = (words >= max_words);
            wr_empty = (words == 0);
            #1;
            if (wr_req && wr_full) viol++;
            if (wr_req && !wr_full) begin
                if (lat < 0) lat = cyc;
                check_output("burst wr_data", 32'(wr_data), 32'(exp_data));
                exp_data = exp_data + 8'd1;
                last     = wr_data;
                words++;
            end
            if (burst_done) begin
                done_seen = 1'b1;
                check_output("done busy", 32'(busy), 32'(0));
                check_output("done burst_len", 32'(burst_len), 32'(exp_len));
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check_output("burst_done seen", 32'(done_seen), 32'(1));
        check_output("burst word count", 32'(words), 32'(exp_len));
        check_output("start latency", 32'(lat), 32'(SETTLE_CYC + 1));
        check_output("wr_req while full", 32'(viol), 32'(0));
        check_output("last wr_data", 32'(last), 32'(exp_last));
        @(posedge clk);
        #1;
        check_output("burst_done one cycle", 32'(burst_done), 32'(0));
        check_output("burst_len held", 32'(burst_len), 32'(exp_len));
        wr_full  = 1'b0;
        wr_empty = 1'b1;
    endtask

    task automatic reset_mid_burst();
        int words;
        int cyc;
        words = 0;
        en = 1'b1; wr_full = 1'b0; wr_empty = 1'b1;
        @(posedge clk);
        #1;
        en  = 1'b0;
        cyc = 1;
        while (words < 100 && cyc < 2000) begin
            wr_empty = (words == 0);
            #1;
            if (wr_req) begin
                check_output("pre-reset wr_data", 32'(wr_data), 32'(exp_data));
                exp_data = exp_data + 8'd1;
                words++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check_output("pre-reset words", 32'(words), 32'(100));
        rst      = 1'b1;
        wr_empty = 1'b0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        wr_empty = 1'b1;
        #1;
        check_output("rst wr_req", 32'(wr_req), 32'(0));
        check_output("rst wr_data", 32'(wr_data), 32'(0));
        check_output("rst busy", 32'(busy), 32'(0));
        check_output("rst burst_done", 32'(burst_done), 32'(0));
        check_output("rst burst_len", 32'(burst_len), 32'(0));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_output("post-rst burst_done", 32'(burst_done), 32'(0));
            check_output("post-rst wr_req", 32'(wr_req), 32'(0));
        end
        exp_data = 8'h00;
    endtask

    initial begin
        // rst  en  full empty | req busy done data   len
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0);
        vecs[2]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0);
        vecs[3]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0);
        vecs[5]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 9'd0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 9'd0);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 9'd0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 9'd0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 9'd0);
        vecs[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 9'd0);
        vecs[12] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 9'd2);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 9'd2);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 9'd2);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 9'd2);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 9'd2);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 9'd2);
        vecs[18] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 9'd2);
        vecs[19] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 9'd0);
        vecs[20] = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 9'd0);

        rst = 1'b1; en = 1'b0; wr_full = 1'b0; wr_empty = 1'b1;
        exp_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i], i);
        end

        rst = 1'b1; en = 1'b0; wr_full = 1'b0; wr_empty = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_output("reset wr_data", 32'(wr_data), 32'(0));
        exp_data = 8'h00;

        run_burst(DEPTH, 8'hFF, DEPTH);
        run_burst(DEPTH, 8'hFF, DEPTH);
        run_burst(10, 8'h09, 10);
        run_burst(DEPTH, 8'h09, DEPTH);
        reset_mid_burst();
        run_burst(DEPTH, 8'hFF, DEPTH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
